// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the 5-stage pipeline (master) and the pipeline sequencer (slave).
// Carries stall requests, the resolved-branch pulse, and the stall/flush/redirect controls.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
) ();
    logic             stallreq_if_i;
    logic             stallreq_id_i;
    logic             stallreq_mem_i;
    logic             ex_b_flag_i;
    logic [31:0]      ex_b_target_i;
    logic [5:0]       stall_o;
    logic             flush_o;
    logic             redirect_o;
    logic [31:0]      redirect_pc_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output stallreq_if_i, stallreq_id_i, stallreq_mem_i, ex_b_flag_i, ex_b_target_i,
        input  stall_o, flush_o, redirect_o, redirect_pc_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  stallreq_if_i, stallreq_id_i, stallreq_mem_i, ex_b_flag_i, ex_b_target_i,
        output stall_o, flush_o, redirect_o, redirect_pc_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall bus, branch flush and PC redirect; a branch resolved under a MEM stall is held and replayed on release.
// Redirect is combinational (0 cycles) after the branch pulse or MEM release; PIPE_CTRL_PERF_EN adds saturating stall/flush counters.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave pipe
);
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_PEND      = 2'd1;
    localparam logic [1:0] S_FLUSH     = 2'd2;
    localparam logic [2:0] FLUSH_INIT  = 3'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_pend_pc;
    logic [31:0] w_pend_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_flush;
    logic [5:0]  w_stall;

    always_comb begin
        w_state_nxt   = r_state;
        w_pend_nxt    = r_pend_pc;
        w_cnt_nxt     = r_cnt;
        w_redirect    = 1'b0;
        w_redirect_pc = '0;
        w_flush       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (pipe.ex_b_flag_i) begin
                    if (pipe.stallreq_mem_i) begin
                        w_pend_nxt  = pipe.ex_b_target_i;
                        w_state_nxt = S_PEND;
                    end else begin
                        w_redirect    = 1'b1;
                        w_redirect_pc = pipe.ex_b_target_i;
                    end
                end
            end
            S_PEND: begin
                if (!pipe.stallreq_mem_i) begin
                    w_redirect    = 1'b1;
                    w_redirect_pc = r_pend_pc;
                    w_state_nxt   = S_IDLE;
                end
            end
            S_FLUSH: begin
                w_flush   = 1'b1;
                w_cnt_nxt = r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Every redirect starts the flush window, whichever state issued it.
        if (w_redirect) begin
            w_flush = 1'b1;
            if (MULTI_FLUSH) begin
                w_state_nxt = S_FLUSH;
                w_cnt_nxt   = FLUSH_INIT;
            end
        end
    end

    // The instruction an ID/IF stall would hold is being killed, so flush masks those requests.
    always_comb begin
        w_stall = 6'b000000;
        if (pipe.stallreq_mem_i) begin
            w_stall = 6'b011111;
        end else if (pipe.stallreq_id_i && !w_flush) begin
            w_stall = 6'b000111;
        end else if (pipe.stallreq_if_i && !w_flush) begin
            w_stall = 6'b000011;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_pend_pc <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend_pc <= w_pend_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign pipe.stall_o       = rst ? w_stall       : 6'b000000;
    assign pipe.flush_o       = rst ? w_flush       : 1'b0;
    assign pipe.redirect_o    = rst ? w_redirect    : 1'b0;
    assign pipe.redirect_pc_o = rst ? w_redirect_pc : 32'h0;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((w_stall != 6'b000000) && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_redirect && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign pipe.stall_cnt_o = r_stall_cnt;
    assign pipe.flush_cnt_o = r_flush_cnt;
`else
    assign pipe.stall_cnt_o = '0;
    assign pipe.flush_cnt_o = '0;
`endif

`ifndef SYNTHESIS
    // EX is frozen while a branch is pending, so a second branch pulse indicates an upstream bug.
    a_no_branch_in_pend: assert property (@(posedge clk) disable iff (!rst)
        (r_state == S_PEND) |-> !pipe.ex_b_flag_i)
        else $error("pipe_ctrl: ex_b_flag_i asserted while a branch is pending");
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (FLUSH_CYCLES=3 and 1) share stimulus; a queue scoreboard holds expected outputs.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(4)) pif3 ();
    pipe_ctrl_if #(.CNT_W(4)) pif1 ();

    pipe_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) u_dut3 (.clk(clk), .rst(rst), .pipe(pif3.slave));
    pipe_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) u_dut1 (.clk(clk), .rst(rst), .pipe(pif1.slave));

    assign pif1.stallreq_if_i  = pif3.stallreq_if_i;
    assign pif1.stallreq_id_i  = pif3.stallreq_id_i;
    assign pif1.stallreq_mem_i = pif3.stallreq_mem_i;
    assign pif1.ex_b_flag_i    = pif3.ex_b_flag_i;
    assign pif1.ex_b_target_i  = pif3.ex_b_target_i;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {logic [5:0] stall; logic flush; logic redir; logic [31:0] pc;} obs_t;
    typedef struct packed {obs_t d3; obs_t d1;} exp_t;
    typedef struct packed {logic [3:0] req; logic [31:0] tgt;} stim_t;

    localparam obs_t Z = '0;
    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // req = {if, id, mem, branch}
    function automatic stim_t S(input logic [3:0] req, input logic [31:0] tgt);
        return {req, tgt};
    endfunction

    // fr = {flush, redirect}
    function automatic obs_t O(input logic [5:0] st, input logic [1:0] fr, input logic [31:0] pc);
        return {st, fr, pc};
    endfunction

    function automatic exp_t E(input obs_t a, input obs_t b);
        return {a, b};
    endfunction

    function automatic exp_t observe();
        return {pif3.stall_o, pif3.flush_o, pif3.redirect_o, pif3.redirect_pc_o,
                pif1.stall_o, pif1.flush_o, pif1.redirect_o, pif1.redirect_pc_o};
    endfunction

    task automatic apply(input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        pif3.stallreq_if_i  = s.req[3];
        pif3.stallreq_id_i  = s.req[2];
        pif3.stallreq_mem_i = s.req[1];
        pif3.ex_b_flag_i    = s.req[0];
        pif3.ex_b_target_i  = s.tgt;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t got, e;
        repeat (2) @(negedge clk);
        pif3.stallreq_mem_i = 1'b1;
        pif3.ex_b_flag_i    = 1'b1;
        pif3.ex_b_target_i  = 32'h123;
        exp_q.push_back('0);
        #1;
        got = observe();
        e   = exp_q.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected %h", got, e);
        end
        n_tests++;
        if (pif3.stall_cnt_o !== 4'h0 || pif3.flush_cnt_o !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_counters: got %h/%h, expected 0/0", pif3.stall_cnt_o, pif3.flush_cnt_o);
        end
        pif3.stallreq_mem_i = 1'b0;
        pif3.ex_b_flag_i    = 1'b0;
        pif3.ex_b_target_i  = 32'h0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_id_stall();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, e;
        st = '{S(4'b0100, 32'h0), S(4'b0000, 32'h0)};
        ex = '{E(O(6'b000111, 2'b00, 32'h0), O(6'b000111, 2'b00, 32'h0)), E(Z, Z)};
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            @(negedge clk);
            got = observe();
            e   = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL id_stall[%0d]: got %h, expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_stall_priority();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, e;
        obs_t  m, f, d;
        m  = O(6'b011111, 2'b00, 32'h0);
        f  = O(6'b000011, 2'b00, 32'h0);
        d  = O(6'b000111, 2'b00, 32'h0);
        st = '{S(4'b0110, 32'h0), S(4'b1000, 32'h0), S(4'b1100, 32'h0), S(4'b1110, 32'h0), S(4'b0000, 32'h0)};
        ex = '{E(m, m), E(f, f), E(d, d), E(m, m), E(Z, Z)};
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            @(negedge clk);
            got = observe();
            e   = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL stall_priority[%0d]: got %h, expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_branch_flush();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, e;
        obs_t  r, fl;
        r  = O(6'b000000, 2'b11, 32'h0000_1040);
        fl = O(6'b000000, 2'b10, 32'h0);
        st = '{S(4'b0001, 32'h0000_1040), S(4'b0000, 32'h0), S(4'b0000, 32'h0), S(4'b0000, 32'h0)};
        ex = '{E(r, r), E(fl, Z), E(fl, Z), E(Z, Z)};
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            @(negedge clk);
            got = observe();
            e   = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL branch_flush[%0d]: got %h, expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_mem_pending();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, e;
        obs_t  m, r, fl;
        m  = O(6'b011111, 2'b00, 32'h0);
        r  = O(6'b000000, 2'b11, 32'h200);
        fl = O(6'b000000, 2'b10, 32'h0);
        st = '{S(4'b0011, 32'h200), S(4'b0010, 32'h0), S(4'b0110, 32'h0), S(4'b1010, 32'h0),
               S(4'b0000, 32'h0), S(4'b0000, 32'h0), S(4'b0000, 32'h0), S(4'b0000, 32'h0)};
        ex = '{E(m, m), E(m, m), E(m, m), E(m, m), E(r, r), E(fl, Z), E(fl, Z), E(Z, Z)};
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            @(negedge clk);
            got = observe();
            e   = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL mem_pending[%0d]: got %h, expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_flush_masks_id();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, e;
        st = '{S(4'b0101, 32'h300), S(4'b1101, 32'h400), S(4'b0010, 32'h0), S(4'b0000, 32'h0)};
        ex = '{E(O(6'b000000, 2'b11, 32'h300), O(6'b000000, 2'b11, 32'h300)),
               E(O(6'b000000, 2'b10, 32'h0),   O(6'b000000, 2'b11, 32'h400)),
               E(O(6'b011111, 2'b10, 32'h0),   O(6'b011111, 2'b00, 32'h0)),
               E(Z, Z)};
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            @(negedge clk);
            got = observe();
            e   = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL flush_masks_id[%0d]: got %h, expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_reset_pend();
        exp_t       got, e;
        obs_t       m, fi, r, fl;
        logic [3:0] exp_cnt;
        m  = O(6'b011111, 2'b00, 32'h0);
        fi = O(6'b000011, 2'b00, 32'h0);
        r  = O(6'b000000, 2'b11, 32'h600);
        fl = O(6'b000000, 2'b10, 32'h0);
        for (int i = 0; i < 2; i++) begin
            apply(S((i == 0) ? 4'b0011 : 4'b0010, 32'h500), E(m, m));
            @(negedge clk);
            got = observe();
            e   = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL pend_enter[%0d]: got %h, expected %h", i, got, e);
            end
        end
        rst = 1'b0;
        exp_q.push_back('0);
        #1;
        got = observe();
        e   = exp_q.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_in_pend: got %h, expected %h", got, e);
        end
        apply(S(4'b0000, 32'h0), E(Z, Z));
        @(negedge clk);
        rst = 1'b1;
        void'(exp_q.pop_front());
        for (int i = 0; i < 3; i++) begin
            apply(S(4'b0000, 32'h0), E(Z, Z));
            @(negedge clk);
            got = observe();
            e   = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL no_replay[%0d]: got %h, expected %h", i, got, e);
            end
        end
        for (int i = 0; i < 20; i++) begin
            apply(S(4'b1000, 32'h0), E(fi, fi));
            @(negedge clk);
            got = observe();
            e   = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL if_stall_run[%0d]: got %h, expected %h", i, got, e);
            end
            if (i == 5 || i == 19) begin
                exp_cnt = PERF ? ((i == 5) ? 4'd5 : 4'hF) : 4'h0;
                n_tests++;
                if (pif3.stall_cnt_o !== exp_cnt) begin
                    n_fail++;
                    $display("FAIL stall_cnt[%0d]: got %h, expected %h", i, pif3.stall_cnt_o, exp_cnt);
                end
            end
        end
        apply(S(4'b0001, 32'h600), E(r, r));
        @(negedge clk);
        got = observe();
        e   = exp_q.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL redirect_after_reset: got %h, expected %h", got, e);
        end
        exp_cnt = PERF ? 4'hF : 4'h0;
        n_tests++;
        if (pif3.stall_cnt_o !== exp_cnt) begin
            n_fail++;
            $display("FAIL stall_cnt_saturate: got %h, expected %h", pif3.stall_cnt_o, exp_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            apply(S(4'b0000, 32'h0), E((i < 2) ? fl : Z, Z));
            @(negedge clk);
            got = observe();
            e   = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL flush_tail[%0d]: got %h, expected %h", i, got, e);
            end
        end
        exp_cnt = PERF ? 4'h1 : 4'h0;
        n_tests++;
        if (pif3.flush_cnt_o !== exp_cnt) begin
            n_fail++;
            $display("FAIL flush_cnt: got %h, expected %h", pif3.flush_cnt_o, exp_cnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        pif3.stallreq_if_i  = 1'b0;
        pif3.stallreq_id_i  = 1'b0;
        pif3.stallreq_mem_i = 1'b0;
        pif3.ex_b_flag_i    = 1'b0;
        pif3.ex_b_target_i  = 32'h0;
        test_reset();
        test_id_stall();
        test_stall_priority();
        test_branch_flush();
        test_mem_pending();
        test_flush_masks_id();
        test_reset_pend();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
